// File: rtl/pc_unit.sv
// Program counter with RUN/HALT control, redirect priority and a flush pulse.
// Define PC_UNIT_RAS_EN to compile in the circular return-address stack.
module pc_unit #(
   parameter int PC_W      = 16,
   parameter int RESET_PC  = 0,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            pc_branch_sel,
   input  logic [PC_W-1:0] branch_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            call,
   input  logic            ret,
   input  logic            halt,
   input  logic            resume,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus1,
   output logic            flush,
   output logic            halted,
   output logic            ras_err
);

   localparam int RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;
   logic [PC_W-1:0]   pc_r;
   logic [PC_W-1:0]   pc_nx_s;
   logic              flush_r;
   logic              redirect_s;
   logic              push_s;
   logic              pop_s;
   logic              ret_go_s;
   logic [PC_W-1:0]   ret_pc_s;

   assign pc       = pc_r;
   assign pc_plus1 = pc_r + PC_W'(1);
   assign flush    = flush_r;
   assign halted   = (state_r == ST_HALT);

`ifdef PC_UNIT_RAS_EN
   logic [PC_W-1:0]   ras_mem_r [RAS_DEPTH];
   logic [RAS_AW-1:0] top_r;
   logic [RAS_AW:0]   cnt_r;
   logic              ras_err_r;
   logic [RAS_AW-1:0] top_inc_s;
   logic              ras_empty_s;
   logic              ras_full_s;

   assign top_inc_s   = top_r + RAS_AW'(1);
   assign ras_empty_s = (cnt_r == (RAS_AW+1)'(0));
   assign ras_full_s  = (cnt_r == (RAS_AW+1)'(RAS_DEPTH));
   // Call takes precedence over a simultaneous return.
   assign ret_go_s    = ret & ~call;
   assign ret_pc_s    = ras_empty_s ? pc_plus1 : ras_mem_r[top_r];
   assign ras_err     = ras_err_r;

   // Return stack: a full push overwrites the oldest slot; an empty pop only flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_mem_r[i] <= '0;
         end
         top_r     <= '0;
         cnt_r     <= '0;
         ras_err_r <= 1'b0;
      end else if (push_s) begin
         ras_mem_r[top_inc_s] <= pc_plus1;
         top_r                <= top_inc_s;
         if (ras_full_s) begin
            ras_err_r <= 1'b1;
         end else begin
            cnt_r <= cnt_r + (RAS_AW+1)'(1);
         end
      end else if (pop_s) begin
         if (ras_empty_s) begin
            ras_err_r <= 1'b1;
         end else begin
            top_r <= top_r - RAS_AW'(1);
            cnt_r <= cnt_r - (RAS_AW+1)'(1);
         end
      end else begin
         ras_err_r <= ras_err_r;
      end
   end
`else
   logic [RAS_AW+2:0] unused_ras_s;

   assign ret_go_s     = 1'b0;
   assign ret_pc_s     = pc_plus1;
   assign ras_err      = 1'b0;
   assign unused_ras_s = {{RAS_AW{1'b0}}, ret, push_s, pop_s};
`endif

   // Next-state and next-PC selection; halt beats every redirect in RUN.
   always_comb begin
      state_nx_s = state_r;
      pc_nx_s    = pc_r;
      redirect_s = 1'b0;
      push_s     = 1'b0;
      pop_s      = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (halt) begin
               state_nx_s = ST_HALT;
            end else if (ret_go_s) begin
               pc_nx_s    = ret_pc_s;
               redirect_s = 1'b1;
               pop_s      = 1'b1;
            end else if (call) begin
               pc_nx_s    = jump_target;
               redirect_s = 1'b1;
               push_s     = 1'b1;
            end else if (jump) begin
               pc_nx_s    = jump_target;
               redirect_s = 1'b1;
            end else if (pc_branch_sel) begin
               pc_nx_s    = branch_target;
               redirect_s = 1'b1;
            end else if (stall) begin
               pc_nx_s = pc_r;
            end else begin
               pc_nx_s = pc_plus1;
            end
         end
         ST_HALT: begin
            if (resume) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_HALT;
            end
         end
         default: begin
            state_nx_s = ST_RUN;
         end
      endcase
   end

   // PC, state and flush registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
         pc_r    <= PC_W'(RESET_PC);
         flush_r <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         pc_r    <= pc_nx_s;
         flush_r <= redirect_s;
      end
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter PC_W, default 16, width of the program counter and all address ports.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4, number of return-address stack entries, power of two, used only with RAS_EN.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port stall  input  1  hold PC this cycle.
REQ-007 Port pc_branch_sel  input  1  registered taken-branch indication from the branch-logic stage.
REQ-008 Port branch_target  input  PC_W  branch destination, valid while pc_branch_sel=1.
REQ-009 Port jump  input  1  unconditional jump request.
REQ-010 Port jump_target  input  PC_W  jump/call destination.
REQ-011 Port call  input  1  call request: push return address, go to jump_target.
REQ-012 Port ret  input  1  return request: pop return address into PC.
REQ-013 Port halt  input  1  halt instruction decoded.
REQ-014 Port resume  input  1  leave halted state.
REQ-015 Port pc  output  PC_W  current fetch address, registered.
REQ-016 Port pc_plus1  output  PC_W  pc+1 modulo 2^PC_W, combinational.
REQ-017 Port flush  output  1  registered one-cycle pulse after any redirect.
REQ-018 Port halted  output  1  high while in HALT state.
REQ-019 Port ras_err  output  1  sticky return-stack overflow/underflow flag.

Function
REQ-020 Two states, RUN and HALT; RUN->HALT on halt; HALT->RUN on resume; all other inputs ignored in HALT.
REQ-021 In RUN, next-PC priority: halt (hold) > ret > call > jump > pc_branch_sel > stall (hold) > pc+1.
REQ-022 Redirects (ret, call, jump, pc_branch_sel) take effect even when stall=1 and are never lost.
REQ-023 Redirect loads its target into pc on the next rising edge, zero-cycle bubble in this block.
REQ-024 flush is 1 for exactly the cycle after a redirect edge, else 0; consecutive redirects give consecutive flush cycles.
REQ-025 pc wraps from 2^PC_W-1 to 0 on increment with no flag.
REQ-026 On the resume edge pc is unchanged; increment resumes the following cycle.
REQ-027 halt and resume in the same RUN cycle: halt wins; in HALT, resume wins.
REQ-028 halted is 1 on the cycle after the halt edge and 0 on the cycle after the resume edge.

Reset
REQ-029 rst_n low immediately forces pc=RESET_PC, state RUN, flush=0, halted=0, ras_err=0, return stack empty, independent of clk.
REQ-030 Reset asserted mid-redirect or in HALT discards the pending operation; the first edge after release increments from RESET_PC.

Configuration
REQ-031 Macro PC_UNIT_RAS_EN compiles in the return-address stack.
REQ-032 With PC_UNIT_RAS_EN: call pushes pc_plus1, ret pops into pc; call and ret together, call wins and ret ignored.
REQ-033 With PC_UNIT_RAS_EN: push when full overwrites oldest entry and sets ras_err; pop when empty loads pc_plus1 and sets ras_err; ras_err clears only on reset.
REQ-034 Without PC_UNIT_RAS_EN: call behaves as jump, ret ignored, ras_err tied 0; port list identical.

Verification
REQ-035 Reset release, no requests, 5 edges -> pc 0,1,2,3,4,5; flush=0 throughout.
REQ-036 pc=0x0010, pc_branch_sel=1, branch_target=0x0040, stall=1 -> next pc=0x0040, flush=1 one cycle, then pc=0x0041.
REQ-037 pc=0xFFFF, no requests -> pc=0x0000, no flag; halt at pc=0x0002 together with jump -> pc holds 0x0002, halted=1; resume -> pc 0x0002 then 0x0003.
REQ-038 PC_UNIT_RAS_EN: call at pc=0x0100 to 0x0200, ret at 0x0205 -> pc 0x0200 then 0x0101, flush pulses both times, ras_err=0.
REQ-039 PC_UNIT_RAS_EN: 5 calls without ret then 5 rets -> ras_err=1 after 5th call; rets return newest four addresses, 5th ret yields pc_plus1.
REQ-040 rst_n pulsed low mid-cycle during a jump request -> pc=RESET_PC immediately, flush=0, no jump after release.
